alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Multi-cycle issue and writeback sequencer that drives the CPU's combinational ALU.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it to an ALUop.
- Reads operands from an internal 8x16 register file and presents A/B/ALUop to the ALU.
- Captures ALUout and overflow, writes the result back, and maintains a sticky overflow flag.

Parameters:
- CPU_WIDTH, 16, datapath and register width; also the ALU operand width.
- REG_NUM, 8, register count; r0 reads as zero.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  16  instruction word.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  sequencer can accept; high only in IDLE.
- alu_a  output  CPU_WIDTH  ALU operand A.
- alu_b  output  CPU_WIDTH  ALU operand B.
- alu_op  output  3  ALU operation code.
- alu_out  input  CPU_WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_ovf  input  1  ALU overflow.
- wb_valid  output  1  one-cycle writeback pulse.
- wb_rd  output  3  writeback destination register.
- wb_data  output  CPU_WIDTH  writeback value.
- illegal  output  1  one-cycle pulse for an undefined opcode.
- ovf_flag  output  1  sticky overflow flag.
- ovf_clr  input  1  clears ovf_flag.
- dbg_addr  input  3  debug register-file read address.
- dbg_data  output  CPU_WIDTH  combinational read of register dbg_addr.

Behaviour:
- Instruction format:
  - [15:12] opcode; [11:9] rd; [8:6] rs1.
  - R-type: [5:3] rs2.
  - I-type: [5:0] imm6, sign-extended to CPU_WIDTH.
- Opcode decode:
  - Opcode bit3 = 0: R-type. Bit3 = 1: I-type, B = sext(imm6).
  - Opcode[2:0] maps directly to ALUop: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLL=101, SRL=110.
  - Opcode[2:0]=111 (0111, 1111) is illegal.
- FSM states and transitions:
  - IDLE -> DECODE on instr_valid && instr_ready.
  - DECODE -> EXEC.
  - EXEC -> WB.
  - WB -> IDLE.
- Cycle behaviour:
  - DECODE: latch rd, the ALUop, opA = RF[rs1], and opB = RF[rs2] or sext(imm6) into registers.
  - EXEC: alu_a/alu_b/alu_op are driven from those registers. alu_out and alu_ovf are sampled at the end of EXEC.
  - WB: wb_valid=1 with wb_rd/wb_data; RF[rd] is written on the clock edge ending WB.
- Throughput and latency:
  - One instruction per 4 cycles.
  - Handshake to wb_valid = 3 cycles.
  - A following instruction sees the prior write; no forwarding is needed.
- alu_a/alu_b/alu_op are registered. Outside EXEC they hold their last values; only EXEC values are meaningful.
- rd = 0: wb_valid still pulses with the computed data, but RF is not written. RF[0] always reads 0.
- Illegal opcode: no RF write; wb_valid stays 0; illegal=1 during the WB cycle; ovf_flag is unaffected.
- ovf_flag:
  - Set on the EXEC->WB edge when alu_ovf=1 and op is ADD or SUB.
  - ovf_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- instr_valid while not IDLE is ignored; the source holds instr until ready.
- Reset values:
  - State IDLE; instr_ready=1.
  - wb_valid=0, illegal=0, ovf_flag=0.
  - alu_a=0, alu_b=0, alu_op=000 (ADD).
  - All RF entries 0.
- Reset mid-operation aborts the instruction with no writeback.
- dbg_data is combinational and reflects a write from the edge after WB.

Decomposition:
- para.v holds shared constants: ALUop codes (ADD_op..SRL_op), opcode field positions, and FSM state encodings.
- One sub-module, alu_issue_regfile:
  - REG_NUM x CPU_WIDTH storage.
  - Two read ports plus the debug read port.
  - One write port with r0 write-suppress.
  - Asynchronous clear on rst.

Test Plan:
- Reset, then ADDI r1,r0,#5 (0x8205) -> wb_valid 3 cycles after the handshake, wb_rd=1, wb_data=0x0005; dbg_addr=1 -> 0x0005.
- r1=0x7FFF, r2=0x0001; ADD r3,r1,r2 -> wb_data=0x8000, ovf_flag=1. Pulse ovf_clr with no overflow -> ovf_flag=0.
- SUB r4,r2,r1 with r2=1, r1=3 -> wb_data=0xFFFE, ovf_flag unchanged. SLL by 4 of 0x0003 -> 0x0030.
- Opcode 0111 -> illegal pulses in cycle 3; wb_valid=0; RF unchanged; instr_ready returns high in the next cycle.
- Write to r0 with imm 0x1F -> wb_valid=1, wb_data=0x001F; dbg_addr=0 still reads 0.
- Back-to-back instr_valid held high -> instr_ready high every 4th cycle only. Assert rst during EXEC -> no wb_valid; all RF entries and outputs return to reset values.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants for the ALU issue/writeback sequencer.
//   - ALUop codes driven on alu_op
//   - instruction field positions
//   - sequencer FSM state encoding
package alu_issue_pkg;

  localparam int CPU_WIDTH_DEF = 16;
  localparam int REG_NUM_DEF   = 8;
  localparam int INSTR_W       = 16;

  // ALUop codes; opcode[2:0] maps onto these one-to-one
  localparam logic [2:0] ADD_OP = 3'b000;
  localparam logic [2:0] SUB_OP = 3'b001;
  localparam logic [2:0] AND_OP = 3'b010;
  localparam logic [2:0] OR_OP  = 3'b011;
  localparam logic [2:0] XOR_OP = 3'b100;
  localparam logic [2:0] SLL_OP = 3'b101;
  localparam logic [2:0] SRL_OP = 3'b110;
  localparam logic [2:0] ILL_OP = 3'b111;

  // instruction field positions
  localparam int OPC_ITYPE_BIT = 15;
  localparam int OPC_LSB       = 12;
  localparam int RD_LSB        = 9;
  localparam int RS1_LSB       = 6;
  localparam int RS2_LSB       = 3;
  localparam int IMM_LSB       = 0;
  localparam int IMM_W         = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  // only ADD/SUB report overflow into the sticky flag
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == ADD_OP) || (op == SUB_OP);
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: REG_NUM x CPU_WIDTH register file for the issue sequencer.
// Ports:
//   clk, rst                      clock, async active-high clear of all entries
//   rd_addr_a/rd_data_a           operand read port A (combinational)
//   rd_addr_b/rd_data_b           operand read port B (combinational)
//   dbg_addr/dbg_data             debug read port (combinational)
//   wr_en/wr_addr/wr_data         single write port; writes to r0 are dropped
// r0 always reads as zero.
module alu_issue_regfile #(
  parameter int CPU_WIDTH = 16,
  parameter int REG_NUM   = 8,
  parameter int ADDR_W    = $clog2(REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [CPU_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [CPU_WIDTH-1:0] rd_data_b,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [CPU_WIDTH-1:0] dbg_data,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CPU_WIDTH-1:0] wr_data
);

  logic [CPU_WIDTH-1:0] mem [REG_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // r0 is forced to zero at the read mux so it never depends on storage
  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];
  assign dbg_data  = (dbg_addr  == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: multi-cycle issue/writeback sequencer in front of a combinational ALU.
// Ports:
//   clk, rst              clock, async active-high reset
//   instr/instr_valid     instruction input, accepted when instr_ready is high
//   instr_ready           high only in IDLE
//   alu_a/alu_b/alu_op    registered ALU operands/op, meaningful during EXEC
//   alu_out/alu_ovf       combinational ALU result, sampled at the end of EXEC
//   wb_valid/wb_rd/wb_data one-cycle writeback pulse with destination and value
//   illegal               one-cycle pulse (WB cycle) for opcode[2:0] == 111
//   ovf_flag/ovf_clr      sticky ADD/SUB overflow flag and its clear
//   dbg_addr/dbg_data     combinational debug register read
//
// state  | meaning
// IDLE   | waiting for instr_valid; instr_ready high
// DECODE | fields of the captured instruction decoded, operands latched
// EXEC   | alu_a/alu_b/alu_op presented; result sampled on exit
// WB     | wb_valid or illegal high; RF written on exit
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int CPU_WIDTH = CPU_WIDTH_DEF,
  parameter int REG_NUM   = REG_NUM_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [CPU_WIDTH-1:0] alu_a,
  output logic [CPU_WIDTH-1:0] alu_b,
  output logic [2:0]           alu_op,
  input  logic [CPU_WIDTH-1:0] alu_out,
  input  logic                 alu_ovf,
  output logic                 wb_valid,
  output logic [2:0]           wb_rd,
  output logic [CPU_WIDTH-1:0] wb_data,
  output logic                 illegal,
  output logic                 ovf_flag,
  input  logic                 ovf_clr,
  input  logic [2:0]           dbg_addr,
  output logic [CPU_WIDTH-1:0] dbg_data
);

  state_e               state;
  logic [INSTR_W-1:0]   instr_q;
  logic [2:0]           rd_q;
  logic                 ill_q;
  logic [CPU_WIDTH-1:0] rs1_data;
  logic [CPU_WIDTH-1:0] rs2_data;
  logic [CPU_WIDTH-1:0] imm_sext;
  logic [IMM_W-1:0]     imm6;
  logic                 ovf_set;

  assign instr_ready = (state == S_IDLE);

  assign imm6     = instr_q[IMM_LSB +: IMM_W];
  assign imm_sext = {{(CPU_WIDTH-IMM_W){imm6[IMM_W-1]}}, imm6};

  // alu_op is still holding the EXEC op when this is evaluated
  assign ovf_set = (state == S_EXEC) && !ill_q && alu_ovf && op_is_arith(alu_op);

  alu_issue_regfile #(
    .CPU_WIDTH (CPU_WIDTH),
    .REG_NUM   (REG_NUM),
    .ADDR_W    (3)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (instr_q[RS1_LSB +: 3]),
    .rd_data_a (rs1_data),
    .rd_addr_b (instr_q[RS2_LSB +: 3]),
    .rd_data_b (rs2_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_en     (wb_valid),
    .wr_addr   (wb_rd),
    .wr_data   (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      instr_q  <= '0;
      rd_q     <= '0;
      ill_q    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= ADD_OP;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // capture the word so the source may change it once accepted
          if (instr_valid) begin
            instr_q <= instr;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          rd_q   <= instr_q[RD_LSB +: 3];
          alu_op <= instr_q[OPC_LSB +: 3];
          ill_q  <= (instr_q[OPC_LSB +: 3] == ILL_OP);
          alu_a  <= rs1_data;
          alu_b  <= instr_q[OPC_ITYPE_BIT] ? imm_sext : rs2_data;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          wb_rd    <= rd_q;
          wb_data  <= alu_out;
          wb_valid <= !ill_q;
          illegal  <= ill_q;
          state    <= S_WB;
        end
        S_WB: begin
          wb_valid <= 1'b0;
          illegal  <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // set has priority over a simultaneous clear
      if (ovf_set) begin
        ovf_flag <= 1'b1;
      end else if (ovf_clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed-vector bench for alu_issue with a scoreboard queue.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_ovf;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        illegal;
  logic        ovf_flag;
  logic        ovf_clr;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .alu_ovf     (alu_ovf),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .ovf_flag    (ovf_flag),
    .ovf_clr     (ovf_clr),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // combinational ALU in front of the sequencer
  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_out = alu_a + alu_b;
        alu_ovf = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      3'b001: begin
        alu_out = alu_a - alu_b;
        alu_ovf = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a | alu_b;
      3'b100: alu_out = alu_a ^ alu_b;
      3'b101: alu_out = alu_a << alu_b[3:0];
      3'b110: alu_out = alu_a >> alu_b[3:0];
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic        ill;
    logic [2:0]  rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          hs_log[$];
  logic [15:0] exp_rf [8];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // monitor: every writeback or illegal pulse pops one expectation
  always @(negedge clk) begin
    if (!rst && (wb_valid || illegal)) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", {wb_valid, illegal}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_cycle", cycle, e.cyc);
        chk("illegal", illegal, e.ill);
        chk("wb_valid", wb_valid, !e.ill);
        if (!e.ill) begin
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // called at a negedge; returns at the negedge of the DECODE cycle
  task automatic issue(input logic [15:0] w, input logic ill, input logic [2:0] rd,
                       input logic [15:0] data, input bit keep);
    exp_t e;
    int   n;
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("handshake_timeout", 0, 1);
    e.ill = ill;
    e.rd = rd;
    e.data = data;
    e.cyc = cycle + 3;
    sb.push_back(e);
    hs_log.push_back(cycle);
    if (!ill && rd != 3'd0) exp_rf[rd] = data;
    @(negedge clk);
    if (!keep) instr_valid = 1'b0;
  endtask

  // from DECODE negedge: ready low through WB, high again the cycle after
  task automatic finish_txn();
    @(negedge clk);
    @(negedge clk);
    chk("ready_in_wb", instr_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_wb", instr_ready, 1'b1);
  endtask

  task automatic check_rf();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      chk($sformatf("rf_r%0d", i), dbg_data, exp_rf[i]);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    ovf_clr = 1'b0;
    dbg_addr = '0;
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_ovf_flag", ovf_flag, 1'b0);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_b", alu_b, 16'h0000);
    chk("rst_alu_op", alu_op, 3'b000);
    check_rf();

    // ADDI r1,r0,#5
    issue(16'h8205, 1'b0, 3'd1, 16'h0005, 1'b0);
    finish_txn();
    dbg_addr = 3'd1;
    #1;
    chk("dbg_r1_after_addi", dbg_data, 16'h0005);

    // r1 = 0x7FFF via ADDI -1 then SRLI 1; r2 = 1; ADD r3 overflows
    issue(16'h823F, 1'b0, 3'd1, 16'hFFFF, 1'b0);
    finish_txn();
    issue(16'hE241, 1'b0, 3'd1, 16'h7FFF, 1'b0);
    finish_txn();
    issue(16'h8401, 1'b0, 3'd2, 16'h0001, 1'b0);
    finish_txn();
    chk("ovf_before_add", ovf_flag, 1'b0);
    issue(16'h0650, 1'b0, 3'd3, 16'h8000, 1'b0);
    finish_txn();
    chk("ovf_after_add", ovf_flag, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_after_clr", ovf_flag, 1'b0);

    // overflow with ovf_clr held: set wins at EXEC->WB, clear applies afterwards
    ovf_clr = 1'b1;
    issue(16'h0650, 1'b0, 3'd3, 16'h8000, 1'b0);
    @(negedge clk);
    chk("ovf_clr_in_exec", ovf_flag, 1'b0);
    @(negedge clk);
    chk("ovf_set_wins", ovf_flag, 1'b1);
    @(negedge clk);
    chk("ovf_clr_after_set", ovf_flag, 1'b0);
    ovf_clr = 1'b0;

    // r1 = 3; SUB r4,r2,r1 = 1-3
    issue(16'h8203, 1'b0, 3'd1, 16'h0003, 1'b0);
    finish_txn();
    issue(16'h1888, 1'b0, 3'd4, 16'hFFFE, 1'b0);
    finish_txn();
    chk("ovf_after_sub", ovf_flag, 1'b0);

    // r5 = 3; SLLI r6,r5,4; OR/XORI/ANDI chain on r7
    issue(16'h8A03, 1'b0, 3'd5, 16'h0003, 1'b0);
    finish_txn();
    issue(16'hDD44, 1'b0, 3'd6, 16'h0030, 1'b0);
    finish_txn();
    issue(16'h3FA8, 1'b0, 3'd7, 16'h0033, 1'b0);
    finish_txn();
    issue(16'hCFFF, 1'b0, 3'd7, 16'hFFCC, 1'b0);
    finish_txn();
    issue(16'hAFCF, 1'b0, 3'd7, 16'h000C, 1'b0);
    finish_txn();
    check_rf();

    // illegal opcodes 0111 and 1111, both targeting r1
    issue(16'h7200, 1'b1, 3'd1, 16'h0000, 1'b0);
    finish_txn();
    issue(16'hF3FF, 1'b1, 3'd1, 16'h0000, 1'b0);
    finish_txn();
    chk("ovf_after_illegal", ovf_flag, 1'b0);
    check_rf();

    // ADDI r0,r0,#0x1F: pulse with data, r0 stays zero
    issue(16'h801F, 1'b0, 3'd0, 16'h001F, 1'b0);
    finish_txn();
    dbg_addr = 3'd0;
    #1;
    chk("dbg_r0_after_write", dbg_data, 16'h0000);

    // back-to-back with instr_valid held; second and third use prior results
    hs_log.delete();
    issue(16'h8209, 1'b0, 3'd1, 16'h0009, 1'b1);
    issue(16'h0448, 1'b0, 3'd2, 16'h0012, 1'b1);
    issue(16'h96BE, 1'b0, 3'd3, 16'h0014, 1'b0);
    finish_txn();
    chk("b2b_gap_1", hs_log[1] - hs_log[0], 4);
    chk("b2b_gap_2", hs_log[2] - hs_log[1], 4);
    check_rf();

    // reset asserted during EXEC aborts the instruction
    instr = 16'h8407;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_alu_b_before_rst", alu_b, 16'h0007);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", instr_ready, 1'b1);
    chk("mid_rst_wb_valid", wb_valid, 1'b0);
    chk("mid_rst_alu_a", alu_a, 16'h0000);
    chk("mid_rst_alu_b", alu_b, 16'h0000);
    chk("mid_rst_alu_op", alu_op, 3'b000);
    chk("mid_rst_ovf", ovf_flag, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    check_rf();
    repeat (4) @(negedge clk);
    chk("rst_idle_ready", instr_ready, 1'b1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
